// File: rtl/sdram_write_pkg.sv
// sdram_write_pkg: SDRAM command encodings, engine state encodings and default timings
package sdram_write_pkg;
    localparam logic [2:0] CMD_NOP   = 3'b111;
    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_READ  = 3'b101;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_AR    = 3'b001;
    localparam int T_RCD_DEF = 3;
    localparam int T_WR_DEF  = 2;
    localparam int T_RP_DEF  = 3;
    localparam int T_RFC_DEF = 10;
    localparam int DLY_W     = 4;
    typedef enum logic [7:0] {
        S_IDLE         = 8'd0,
        S_ACTIVATE     = 8'd1,
        S_WRITE_TOP    = 8'd2,
        S_WRITE_BOTTOM = 8'd3,
        S_PRECHARGE    = 8'd4,
        S_REFRESH      = 8'd5,
        S_EMPTY_WAIT   = 8'd6
    } state_e;
endpackage

// File: rtl/sdram_write_if.sv
// sdram_write_if: controller/FIFO/SDRAM-side signals of the write engine
// word_count_o exists only when SDRAM_WRITE_COUNT_EN is defined.
interface sdram_write_if;
    logic        en_i;
    logic [21:0] address_i;
    logic        ready_o;
    logic        auto_refresh_i;
    logic [2:0]  command_o;
    logic [11:0] addr_o;
    logic [1:0]  bank_o;
    logic [15:0] data_out_o;
    logic        data_oe_o;
    logic [31:0] fifo_data_i;
    logic        fifo_empty_i;
    logic        fifo_rd_o;
`ifdef SDRAM_WRITE_COUNT_EN
    logic [31:0] word_count_o;
`endif
    modport slave (
        input  en_i, address_i, auto_refresh_i, fifo_data_i, fifo_empty_i,
        output ready_o, command_o, addr_o, bank_o, data_out_o, data_oe_o, fifo_rd_o
`ifdef SDRAM_WRITE_COUNT_EN
        , output word_count_o
`endif
    );
    modport master (
        output en_i, address_i, auto_refresh_i, fifo_data_i, fifo_empty_i,
        input  ready_o, command_o, addr_o, bank_o, data_out_o, data_oe_o, fifo_rd_o
`ifdef SDRAM_WRITE_COUNT_EN
        , input word_count_o
`endif
    );
endinterface

// File: rtl/sdram_write_delay_timer.sv
// sdram_write_delay_timer: loadable down-counter with zero flag for SDRAM command spacing
module sdram_write_delay_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         zero_o
);
    logic [W-1:0] count_q, count_d;
    assign zero_o = (count_q == '0);
    always_comb count_d = load_i ? value_i : (zero_o ? count_q : count_q - 1'b1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count_q <= '0;
        else count_q <= count_d;
endmodule

// File: rtl/sdram_write.sv
// sdram_write: pops 32-bit FIFO words and writes each as two 16-bit SDRAM column writes.
// Optional SDRAM_WRITE_COUNT_EN adds a popped-word counter on word_count_o.
module sdram_write
    import sdram_write_pkg::*;
#(
    parameter int T_RCD = T_RCD_DEF,
    parameter int T_WR  = T_WR_DEF,
    parameter int T_RP  = T_RP_DEF,
    parameter int T_RFC = T_RFC_DEF
) (
    input logic          clk,
    input logic          rst_n,
    sdram_write_if.slave bus
);
    state_e             state_q, state_d;
    logic [21:0]        laddress_q, laddress_d, laddress_inc;
    logic [15:0]        lword_q, lword_d;
    logic               lrefresh_q, lrefresh_d;
    logic [2:0]         command_q, command_d;
    logic [11:0]        addr_q, addr_d;
    logic [1:0]         bank_q, bank_d;
    logic [15:0]        data_q, data_d;
    logic               oe_q, oe_d;
    logic               fifo_rd;
    logic               load;
    logic [DLY_W-1:0]   load_val;
    logic               zero;
    logic               en, empty;

    sdram_write_delay_timer #(.W(DLY_W)) u_timer (
        .clk(clk), .rst_n(rst_n), .load_i(load), .value_i(load_val), .zero_o(zero)
    );

    assign en           = bus.en_i;
    assign empty        = bus.fifo_empty_i;
    assign laddress_inc = laddress_q + 22'd2;
    assign bus.ready_o    = (state_q == S_IDLE) && zero;
    assign bus.command_o  = command_q;
    assign bus.addr_o     = addr_q;
    assign bus.bank_o     = bank_q;
    assign bus.data_out_o = data_q;
    assign bus.data_oe_o  = oe_q;
    assign bus.fifo_rd_o  = fifo_rd;

    always_comb begin
        state_d    = state_q;
        laddress_d = laddress_q;
        lword_d    = lword_q;
        lrefresh_d = lrefresh_q | (bus.auto_refresh_i & en);
        command_d  = CMD_NOP;
        addr_d     = addr_q;
        bank_d     = bank_q;
        data_d     = data_q;
        oe_d       = 1'b0;
        fifo_rd    = 1'b0;
        load       = 1'b0;
        load_val   = '0;
        if (zero) begin
            case (state_q)
                S_IDLE: begin
                    if (lrefresh_q && en) state_d = S_REFRESH;
                    else if (en && !empty) begin
                        laddress_d = bus.address_i;
                        state_d    = S_ACTIVATE;
                    end
                end
                S_ACTIVATE: begin
                    command_d = CMD_ACT;
                    addr_d    = laddress_q[19:8];
                    bank_d    = laddress_q[21:20];
                    load      = 1'b1;
                    load_val  = DLY_W'(T_RCD);
                    state_d   = S_WRITE_TOP;
                end
                S_WRITE_TOP: begin
                    lword_d   = bus.fifo_data_i[15:0];
                    fifo_rd   = 1'b1;
                    command_d = CMD_WRITE;
                    addr_d    = {4'b0, laddress_q[7:0]};
                    data_d    = bus.fifo_data_i[31:16];
                    oe_d      = 1'b1;
                    state_d   = S_WRITE_BOTTOM;
                end
                S_WRITE_BOTTOM: begin
                    command_d  = CMD_WRITE;
                    addr_d     = {4'b0, laddress_q[7:0] + 8'd1};
                    data_d     = lword_q;
                    oe_d       = 1'b1;
                    laddress_d = laddress_inc;
                    // Close the row at its end, or whenever the burst cannot continue
                    if (laddress_inc[7:0] == 8'h00 || lrefresh_q || !en || empty) begin
                        state_d  = S_PRECHARGE;
                        load     = 1'b1;
                        load_val = DLY_W'(T_WR);
                    end else state_d = S_WRITE_TOP;
                end
                S_PRECHARGE: begin
                    command_d = CMD_PRE;
                    addr_d    = 12'h000;
                    load      = 1'b1;
                    load_val  = DLY_W'(T_RP);
                    state_d   = lrefresh_q ? S_REFRESH : (en && !empty) ? S_ACTIVATE :
                                en ? S_EMPTY_WAIT : S_IDLE;
                end
                S_REFRESH: begin
                    command_d  = CMD_AR;
                    lrefresh_d = 1'b0;
                    load       = 1'b1;
                    load_val   = DLY_W'(T_RFC);
                    state_d    = (en && !empty) ? S_ACTIVATE : en ? S_EMPTY_WAIT : S_IDLE;
                end
                S_EMPTY_WAIT:
                    state_d = !en ? S_IDLE : lrefresh_q ? S_REFRESH : !empty ? S_ACTIVATE : S_EMPTY_WAIT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            laddress_q <= '0;
            lword_q    <= '0;
            lrefresh_q <= 1'b0;
            command_q  <= CMD_NOP;
            addr_q     <= '0;
            bank_q     <= '0;
            data_q     <= '0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            laddress_q <= laddress_d;
            lword_q    <= lword_d;
            lrefresh_q <= lrefresh_d;
            command_q  <= command_d;
            addr_q     <= addr_d;
            bank_q     <= bank_d;
            data_q     <= data_d;
            oe_q       <= oe_d;
        end
    end

`ifdef SDRAM_WRITE_COUNT_EN
    logic [31:0] word_count_q;
    assign bus.word_count_o = word_count_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) word_count_q <= '0;
        else if (state_d == S_IDLE && state_q != S_IDLE && !en) word_count_q <= '0;
        else if (fifo_rd) word_count_q <= word_count_q + 32'd1;
    end
`endif
endmodule

// File: tb/tb_sdram_write.sv
// tb_sdram_write: scoreboard bench; an address-arithmetic model predicts the SDRAM command stream
module tb_sdram_write;
    import sdram_write_pkg::*;

    typedef struct {
        logic [2:0]  cmd;
        int          gap;
        logic [11:0] addr;
        logic [1:0]  bank;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdram_write_if bus();
    sdram_write dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t        exp_q[$];
    logic [31:0] fq[$];
    logic [31:0] push_q[$];
    bit          pend_pop = 1'b0;
    int          checks = 0;
    int          passed = 0;
    int          nops = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, got, want);
    endtask

    // FIFO model: a pop strobed in one cycle takes effect before the next falling edge
    always @(negedge clk) begin
        if (pend_pop && fq.size() > 0) void'(fq.pop_front());
        pend_pop = bus.fifo_rd_o;
        if (bus.fifo_rd_o && fq.size() == 0) check("pop_on_empty", 1, 0);
        while (push_q.size() > 0) fq.push_back(push_q.pop_front());
        bus.fifo_empty_i = (fq.size() == 0);
        bus.fifo_data_i  = (fq.size() > 0) ? fq[0] : 32'h0;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.command_o == CMD_NOP) begin
            nops++;
            if (bus.data_oe_o) check("oe_on_nop", bus.data_oe_o, 0);
        end else begin
            if (exp_q.size() == 0) check("unexpected_cmd", bus.command_o, CMD_NOP);
            else begin
                e = exp_q.pop_front();
                check("cmd", bus.command_o, e.cmd);
                if (e.gap >= 0) check("nop_gap", nops, e.gap);
                if (e.cmd != CMD_AR) begin
                    check("addr", bus.addr_o, e.addr);
                    check("bank", bus.bank_o, e.bank);
                end
                if (e.cmd == CMD_WRITE) begin
                    check("wdata", bus.data_out_o, e.data);
                    check("oe_on_write", bus.data_oe_o, 1);
                end
            end
            nops = 0;
        end
    end

    function automatic exp_t mk(logic [2:0] c, int g, logic [11:0] a, logic [1:0] b, logic [15:0] d);
        exp_t e;
        e.cmd = c; e.gap = g; e.addr = a; e.bank = b; e.data = d;
        return e;
    endfunction

    // Reference: words land at start+2i; a burst ends at row end, refresh, batch end or last word
    task automatic run_scn(input logic [21:0] start, input int n1, input int n2, input int rk,
                           input logic [31:0] fw0, input logic [31:0] fw1);
        logic [31:0] ws[$];
        logic [21:0] a, an;
        logic [7:0]  colp1;
        int n, gap, pops, cyc, since;
        bit act, pushed2;
        n = n1 + n2;
        for (int i = 0; i < n; i++) ws.push_back($urandom);
        if (fw0 != 0) ws[0] = fw0;
        if (fw1 != 0 && n2 > 0) ws[n1] = fw1;
        gap = -1;
        act = 1'b1;
        for (int i = 0; i < n; i++) begin
            a = start + 22'(2 * i);
            an = a + 22'd2;
            colp1 = a[7:0] + 8'd1;
            if (act) exp_q.push_back(mk(CMD_ACT, gap, a[19:8], a[21:20], 16'h0));
            exp_q.push_back(mk(CMD_WRITE, act ? 3 : 0, {4'b0, a[7:0]}, a[21:20], ws[i][31:16]));
            exp_q.push_back(mk(CMD_WRITE, 0, {4'b0, colp1}, a[21:20], ws[i][15:0]));
            act = 1'b0;
            if (an[7:0] == 8'h00 || i == n - 1 || i == n1 - 1 || i == rk) begin
                exp_q.push_back(mk(CMD_PRE, 2, 12'h000, a[21:20], 16'h0));
                gap = 3;
                if (i == rk) begin
                    exp_q.push_back(mk(CMD_AR, 3, 12'h000, 2'b00, 16'h0));
                    gap = 10;
                end
                if (i == n1 - 1) gap = -1;
                act = 1'b1;
            end
        end
        for (int i = 0; i < n1; i++) push_q.push_back(ws[i]);
        repeat (2) @(negedge clk);
        bus.address_i = start;
        bus.en_i = 1'b1;
        pops = 0; cyc = 0; since = 0;
        pushed2 = (n2 == 0);
        while ((exp_q.size() > 0 || !pushed2) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            bus.auto_refresh_i = 1'b0;
            if (bus.fifo_rd_o) begin
                if (pops == rk) bus.auto_refresh_i = 1'b1;
                pops++;
            end
            if (!pushed2 && pops == n1) begin
                since++;
                if (since == 25) begin
                    for (int i = n1; i < n; i++) push_q.push_back(ws[i]);
                    pushed2 = 1'b1;
                end
            end
        end
        bus.auto_refresh_i = 1'b0;
        check("scenario_in_time", cyc < 3000, 1);
        repeat (4) @(negedge clk);
        bus.en_i = 1'b0;
        cyc = 0;
        while (!bus.ready_o && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_after", bus.ready_o, 1);
        check("words_popped", pops, n);
        check("fifo_drained", bus.fifo_empty_i, 1);
        exp_q.delete();
    endtask

    initial begin
        logic [21:0] s;
        int n1, n2, rk;
        bus.en_i = 1'b0;
        bus.address_i = '0;
        bus.auto_refresh_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd", bus.command_o, CMD_NOP);
        check("rst_oe", bus.data_oe_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_idle", bus.ready_o, 1);
        check("fifo_rd_idle", bus.fifo_rd_o, 0);
        check("addr_idle", bus.addr_o, 0);
        check("data_idle", bus.data_out_o, 0);
        check("cmd_idle", bus.command_o, CMD_NOP);
        run_scn(22'h012304, 1, 0, -1, 32'hDEADBEEF, 0);
        run_scn(22'h0567FC, 3, 0, -1, 0, 0);
        run_scn(22'h000010, 1, 1, -1, 0, 32'h11112222);
        run_scn(22'h1ABC20, 4, 0, 1, 0, 0);
        run_scn(22'h3FFFFE, 2, 0, -1, 0, 0);
        for (int k = 0; k < 30; k++) begin
            s = 22'($urandom);
            s[0] = 1'b0;
            if ($urandom_range(0, 1) == 1) s[7:0] = 8'($urandom_range(0, 7) * 2 + 240);
            n1 = $urandom_range(1, 5);
            n2 = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
            rk = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n1 + n2 - 1) : -1;
            run_scn(s, n1, n2, rk, 0, 0);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
